// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU scoreboard: ID sizing, ctrl/wb bundles, entry state.
package fir_xifu_pkg;

  localparam int NID        = 16;
  localparam int X_ID_WIDTH = $clog2(NID);

  typedef struct packed {
    logic [NID-1:0] issue;
    logic [NID-1:0] commit;
    logic [NID-1:0] kill;
  } ctrl2wb_t;

  typedef struct packed {
    logic [NID-1:0] clear;
  } wb2ctrl_t;

  typedef enum logic [1:0] {
    SB_FREE,
    SB_ISSUED,
    SB_COMMITTED,
    SB_KILLED
  } sb_state_e;

endpackage

// File: rtl/fir_xifu_sb_entry.sv
// One scoreboard entry: FREE -> ISSUED -> COMMITTED/KILLED -> FREE.
// Destination register is stored only when FIR_XIFU_HAZARD_CHECK_EN is defined.
module fir_xifu_sb_entry
  import fir_xifu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      accept_i,
  input  logic      commit_i,
  input  logic      kill_i,
  input  logic      clear_i,
  output sb_state_e state_o
`ifdef FIR_XIFU_HAZARD_CHECK_EN
  ,
  input  logic [4:0] rd_i,
  input  logic       rd_we_i,
  output logic [4:0] rd_o,
  output logic       rd_we_o
`endif
);

  sb_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SB_FREE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_FREE:      if (accept_i) state_d = SB_ISSUED;
      SB_ISSUED:    if (commit_i) state_d = kill_i ? SB_KILLED : SB_COMMITTED;
      SB_COMMITTED: if (clear_i)  state_d = SB_FREE;
      SB_KILLED:    state_d = SB_FREE;
      default:      state_d = SB_FREE;
    endcase
  end

  assign state_o = state_q;

`ifdef FIR_XIFU_HAZARD_CHECK_EN
  logic [4:0] rd_q;
  logic       rd_we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else if (accept_i) begin
      rd_q    <= rd_i;
      rd_we_q <= rd_we_i;
    end
  end

  assign rd_o    = rd_q;
  assign rd_we_o = rd_we_q;
`endif

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// Per-ID issue/commit/kill scoreboard with issue gating on ID reuse, occupancy and
// (with FIR_XIFU_HAZARD_CHECK_EN) RAW/WAW hazards against live FIR destinations.
module fir_xifu_scoreboard
  import fir_xifu_pkg::*;
#(
  parameter int NID             = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  input  logic [$clog2(NID)-1:0]   issue_id_i,
  input  logic [4:0]               issue_rd_i,
  input  logic                     issue_rd_we_i,
  input  logic [9:0]               issue_rs_i,
  input  logic [1:0]               issue_rs_valid_i,
  output logic                     issue_ready_o,
  input  logic                     commit_valid_i,
  input  logic [$clog2(NID)-1:0]   commit_id_i,
  input  logic                     commit_kill_i,
  input  logic [NID-1:0]           clear_i,
  output logic [NID-1:0]           issue_o,
  output logic [NID-1:0]           commit_o,
  output logic [NID-1:0]           kill_o,
  output logic [$clog2(NID+1)-1:0] outstanding_o
);

  localparam int IDW = $clog2(NID);
  localparam int CW  = $clog2(NID+1);

  sb_state_e      st [NID];
  logic [NID-1:0] live, committed, killed, leaving;
  logic           accept, hazard;
  logic [CW-1:0]  cnt_q, cnt_d, n_leave;

  assign accept = issue_valid_i & issue_ready_o;

`ifdef FIR_XIFU_HAZARD_CHECK_EN
  logic [4:0] rd_st [NID];
  logic       rd_we_st [NID];
`endif

  for (genvar k = 0; k < NID; k++) begin : g_entry
    fir_xifu_sb_entry u_entry (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .accept_i (accept && (issue_id_i == IDW'(k))),
      .commit_i (commit_valid_i && (commit_id_i == IDW'(k))),
      .kill_i   (commit_kill_i),
      .clear_i  (clear_i[k]),
      .state_o  (st[k])
`ifdef FIR_XIFU_HAZARD_CHECK_EN
      ,
      .rd_i     (issue_rd_i),
      .rd_we_i  (issue_rd_we_i),
      .rd_o     (rd_st[k]),
      .rd_we_o  (rd_we_st[k])
`endif
    );

    assign live[k]      = (st[k] != SB_FREE);
    assign committed[k] = (st[k] == SB_COMMITTED);
    assign killed[k]    = (st[k] == SB_KILLED);
    // Killed entries self-expire; committed ones wait for writeback's clear.
    assign leaving[k]   = killed[k] | (committed[k] & clear_i[k]);
  end

`ifdef FIR_XIFU_HAZARD_CHECK_EN
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NID; k++) begin
      if (live[k] && !killed[k] && rd_we_st[k] &&
          ((issue_rs_valid_i[0] && (rd_st[k] == issue_rs_i[4:0])) ||
           (issue_rs_valid_i[1] && (rd_st[k] == issue_rs_i[9:5])) ||
           (issue_rd_we_i       && (rd_st[k] == issue_rd_i))))
        hazard = 1'b1;
    end
  end
`else
  logic unused_issue_fields;
  assign unused_issue_fields = ^{issue_rd_i, issue_rd_we_i, issue_rs_i, issue_rs_valid_i};
  assign hazard = 1'b0;
`endif

  assign issue_ready_o = ~live[issue_id_i] & (cnt_q < CW'(MAX_OUTSTANDING)) & ~hazard;

  always_comb begin
    n_leave = '0;
    for (int k = 0; k < NID; k++) n_leave = n_leave + CW'(leaving[k]);
    cnt_d = cnt_q + CW'(accept) - n_leave;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign issue_o       = live;
  assign commit_o      = committed;
  assign kill_o        = killed;
  assign outstanding_o = cnt_q;

endmodule
